msk_share_encoder: RTL and testbench
====================================

# msk_share_encoder

- Turns unmasked W-bit words into fresh d-share Boolean sharings, in the codebase's bit-major sharing layout.
- Sits at the boundary where plaintext or key data enters masked datapaths such as the HPC1/DOM gadget pipelines.
- Built-in xorshift64 generator supplies the mask randomness; it is seeded, and periodically reseeded, through a request/valid port.
- Streams 1 word/cycle with valid/ready handshakes and one registered output stage.

## Interface
Parameters:
- d, 2: number of shares; (d-1)*W must be ≤ 64.
- W, 8: unmasked word width.
- RESEED_PERIOD, 1024: encodings allowed per seed (≥1).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- syn_rst  input  1  synchronous, active-high reset.
- seed_req  output  1  high while the block is waiting for a seed.
- seed_valid  input  1  seed_in is valid this cycle.
- seed_in  input  64  seed value.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block accepts in_data this cycle.
- in_data  input  W  unmasked word.
- out_valid  output  1  out_shares holds a sharing.
- out_ready  input  1  consumer takes out_shares this cycle.
- out_shares  output  W*d  sharing; bit i, share j is at index i*d+j.

## Operation
- FSM states: UNSEEDED, RUN, NEEDSEED.
- Reset sends the FSM to UNSEEDED.
- UNSEEDED/NEEDSEED:
  - seed_req=1, in_ready=0.
  - seed_valid loads state s (a zero seed loads 64'h1), clears the encode counter and moves to RUN.
- RUN:
  - seed_req=0.
  - in_ready = !seed_valid & (!out_valid | out_ready).
  - seed_valid reseeds the same way as above and stays in RUN; reseeding has priority over accepting data.
- Encode on accept (in_valid & in_ready):
  - r = s[(d-1)*W-1:0]; share j (1≤j≤d-1) = r[(j-1)*W +: W].
  - share 0 = in_data XOR all other shares.
  - Register the sharing into out_shares and set out_valid.
  - Advance s: s^=s<<13; s^=s>>7; s^=s<<17 (64-bit).
  - Increment the counter.
- s advances only on accept or seed load, never on idle cycles.
- When an accept brings the counter to RESEED_PERIOD, the FSM goes to NEEDSEED at that edge. The already-registered output still drains normally.
- out_valid clears on out_ready when no new accept happens in the same cycle. With a simultaneous accept, the register reloads and out_valid stays 1.
- out_shares holds its value while out_valid & !out_ready.

## Timing
- Reset values (cycle after syn_rst):
  - out_valid=0, out_shares=0, in_ready=0, seed_req=1.
  - s=0, counter=0.
- Reset mid-stream discards the pending output and the seed; the block must be reseeded.
- Latency: accept at edge k gives out_valid=1 after edge k.
- Throughput: 1 word/cycle when out_ready is held high.
- Back-pressure: in_ready depends combinationally on out_ready and seed_valid. No other combinational in→out paths exist.
- First accept can occur in the cycle after the seed-load edge.
- Counter width is clog2(RESEED_PERIOD+1).

## Test plan
- Seed and first two encodings:
  - Stimulus: reset; seed_in=64'h1; then in_data=8'hA5 twice, out_ready=1 (d=2, W=8).
  - First output: shares (s0,s1) = (8'hA4, 8'h01).
  - Second output: (8'hE4, 8'h41), since s = 64'h40822041 after one step.
  - Recombination must equal 8'hA5 both times.
- Zero seed:
  - Stimulus: seed_in=0, then in_data=8'h00.
  - Output shares equal (8'h01, 8'h01), the same stream as seed 1.
- Back-pressure:
  - Stimulus: out_ready=0 for 5 cycles after one accept, with in_valid held.
  - in_ready=0 during the stall, out_shares stable, s not advanced.
  - On out_ready=1, the next word is accepted the same cycle.
- Reseed request:
  - Stimulus: RESEED_PERIOD=4; stream 6 words.
  - Exactly 4 are accepted, then seed_req=1 and in_ready=0.
  - The 4th output still drains.
  - After seed_valid, the remaining 2 are encoded with the new seed.
- Reseed collision:
  - Stimulus: in RUN, seed_valid and in_valid in the same cycle.
  - in_ready=0 and no accept; the seed loads and the counter clears.
  - The word is accepted the next cycle using the new seed's low bits.
- Mid-stream reset:
  - Stimulus: syn_rst with out_valid=1.
  - Next cycle: out_valid=0, out_shares=0, seed_req=1.
  - in_valid is ignored until a reseed.

Source files
------------

// File: rtl/msk_share_encoder_if.sv
// Handshake bundle for msk_share_encoder: seed port, input word stream and
// output sharing stream. The encoder uses the slave modport and the producer/
// consumer side uses the master modport.
interface msk_share_encoder_if #(
    parameter int d = 2,
    parameter int W = 8
);
    logic             seed_req;
    logic             seed_valid;
    logic [63:0]      seed_in;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_data;
    logic             out_valid;
    logic             out_ready;
    logic [W*d-1:0]   out_shares;

    modport master (
        input  seed_req, in_ready, out_valid, out_shares,
        output seed_valid, seed_in, in_valid, in_data, out_ready
    );

    modport slave (
        output seed_req, in_ready, out_valid, out_shares,
        input  seed_valid, seed_in, in_valid, in_data, out_ready
    );
endinterface

// File: rtl/msk_share_encoder.sv
// Boolean masking encoder: turns each unmasked W-bit word into a fresh
// d-share sharing (bit i, share j at index i*d+j). Mask bits come from an
// xorshift64 state that is seeded over the seed port and must be reseeded
// after RESEED_PERIOD encodings. One registered output stage.
// Requires d >= 2 and (d-1)*W <= 64.
module msk_share_encoder #(
    parameter int d             = 2,
    parameter int W             = 8,
    parameter int RESEED_PERIOD = 1024
) (
    input  logic                 clk,
    input  logic                 syn_rst,
    msk_share_encoder_if.slave   bus
);
    localparam int CW = $clog2(RESEED_PERIOD + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(RESEED_PERIOD - 1);

    typedef enum logic [1:0] {
        UNSEEDED = 2'd0,
        RUN      = 2'd1,
        NEEDSEED = 2'd2
    } state_t;

    state_t          state_reg, state_next;
    logic [63:0]     s_reg, s_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic            out_valid_reg, out_valid_next;
    logic [W*d-1:0]  out_shares_reg, out_shares_next;

    logic            seed_req;
    logic            in_ready;
    logic            accept;
    logic [63:0]     s_step;
    logic [W-1:0]    mask [1:d-1];
    logic [W-1:0]    share0;
    logic [W*d-1:0]  sharing;

    // Mask shares are consecutive W-bit slices of the low PRNG state bits
    generate
        for (genvar gi = 1; gi < d; gi++) begin : g_mask
            assign mask[gi] = s_reg[(gi-1)*W +: W];
        end
    endgenerate

    // Share 0 carries the data XOR all mask shares
    always_comb begin
        share0 = bus.in_data;
        for (int j = 1; j < d; j++) begin
            share0 = share0 ^ mask[j];
        end
    end

    // Interleave shares into the bit-major layout
    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_bit
            for (genvar gj = 0; gj < d; gj++) begin : g_share
                if (gj == 0) begin : g_s0
                    assign sharing[gi*d + gj] = share0[gi];
                end else begin : g_sm
                    assign sharing[gi*d + gj] = mask[gj][gi];
                end
            end
        end
    endgenerate

    // One xorshift64 step of the current state
    always_comb begin
        s_step = s_reg ^ (s_reg << 13);
        s_step = s_step ^ (s_step >> 7);
        s_step = s_step ^ (s_step << 17);
    end

    // FSM next state, handshake outputs and datapath next values
    always_comb begin
        state_next      = state_reg;
        s_next          = s_reg;
        cnt_next        = cnt_reg;
        out_valid_next  = out_valid_reg;
        out_shares_next = out_shares_reg;
        seed_req        = 1'b1;
        in_ready        = 1'b0;

        case (state_reg)
            RUN: begin
                seed_req = 1'b0;
                // A seed in the same cycle wins over data
                in_ready = !bus.seed_valid && (!out_valid_reg || bus.out_ready);
            end
            default: ;
        endcase

        accept = bus.in_valid && in_ready;

        if (bus.out_ready) begin
            out_valid_next = 1'b0;
        end

        if (accept) begin
            out_shares_next = sharing;
            out_valid_next  = 1'b1;
            s_next          = s_step;
            cnt_next        = cnt_reg + CW'(1);
            if (cnt_reg == CNT_LAST) begin
                state_next = NEEDSEED;
            end
        end

        // Seed load; an all-zero state would lock xorshift at zero
        if (bus.seed_valid) begin
            s_next     = (bus.seed_in == 64'd0) ? 64'h1 : bus.seed_in;
            cnt_next   = '0;
            state_next = RUN;
        end
    end

    // State and output register
    always_ff @(posedge clk) begin
        if (syn_rst) begin
            state_reg      <= UNSEEDED;
            s_reg          <= '0;
            cnt_reg        <= '0;
            out_valid_reg  <= 1'b0;
            out_shares_reg <= '0;
        end else begin
            state_reg      <= state_next;
            s_reg          <= s_next;
            cnt_reg        <= cnt_next;
            out_valid_reg  <= out_valid_next;
            out_shares_reg <= out_shares_next;
        end
    end

    assign bus.seed_req   = seed_req;
    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid_reg;
    assign bus.out_shares = out_shares_reg;

endmodule

// File: tb/tb_msk_share_encoder.sv
// Self-checking bench for msk_share_encoder (d=2, W=8, RESEED_PERIOD=4).
// A reference model tracks FSM state, PRNG state and a scoreboard of
// expected sharings; every cycle the handshake outputs and the pending
// output register are compared against it.
module tb_msk_share_encoder;
    localparam int D  = 2;
    localparam int W  = 8;
    localparam int RP = 4;
    localparam int SW = W * D;

    logic clk = 1'b0;
    logic syn_rst;
    always #5 clk = ~clk;

    msk_share_encoder_if #(.d(D), .W(W)) bus ();

    msk_share_encoder #(.d(D), .W(W), .RESEED_PERIOD(RP)) dut (
        .clk     (clk),
        .syn_rst (syn_rst),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int dut_acc  = 0;

    // Reference model
    int            m_state = 0;   // 0 unseeded, 1 run, 2 needseed
    logic [63:0]   m_s     = '0;
    int            m_cnt   = 0;
    logic [SW-1:0] sb[$];
    logic [SW-1:0] got_log[$];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] xs(input logic [63:0] s);
        logic [63:0] t;
        t = s ^ (s << 13);
        t = t ^ (t >> 7);
        t = t ^ (t << 17);
        return t;
    endfunction

    function automatic logic [SW-1:0] enc(input logic [W-1:0] data, input logic [63:0] s);
        logic [W-1:0]  sh [D];
        logic [SW-1:0] p;
        sh[0] = data;
        for (int j = 1; j < D; j++) begin
            sh[j] = s[(j-1)*W +: W];
            sh[0] = sh[0] ^ sh[j];
        end
        for (int i = 0; i < W; i++)
            for (int j = 0; j < D; j++)
                p[i*D + j] = sh[j][i];
        return p;
    endfunction

    function automatic logic [W-1:0] get_share(input logic [SW-1:0] p, input int j);
        logic [W-1:0] v;
        for (int i = 0; i < W; i++) v[i] = p[i*D + j];
        return v;
    endfunction

    function automatic logic [W-1:0] recombine(input logic [SW-1:0] p);
        logic [W-1:0] v;
        v = '0;
        for (int j = 0; j < D; j++) v = v ^ get_share(p, j);
        return v;
    endfunction

    // One clock cycle: compare at the falling edge, advance model at the rising edge
    task automatic cycle();
        logic exp_ir, acc, take, sv;
        logic [SW-1:0] obs;
        logic [W-1:0]  din;
        logic [63:0]   sin;
        @(negedge clk);
        exp_ir = (m_state == 1) && !bus.seed_valid && ((sb.size() == 0) || bus.out_ready);
        check_val("seed_req", 64'(bus.seed_req), 64'(m_state != 1));
        check_val("in_ready", 64'(bus.in_ready), 64'(exp_ir));
        check_val("out_valid", 64'(bus.out_valid), 64'(sb.size() != 0));
        obs = bus.out_shares;
        if (sb.size() != 0) check_val("out_shares", 64'(obs), 64'(sb[0]));
        if (bus.in_valid && bus.in_ready && !syn_rst) dut_acc++;
        acc  = exp_ir && bus.in_valid;
        take = (sb.size() != 0) && bus.out_ready;
        sv   = bus.seed_valid;
        din  = bus.in_data;
        sin  = bus.seed_in;
        @(posedge clk);
        if (syn_rst) begin
            sb.delete();
            m_state = 0;
            m_s     = '0;
            m_cnt   = 0;
        end else begin
            if (take) begin
                void'(sb.pop_front());
                got_log.push_back(obs);
                $display("out #%0d shares=%h recombined=%h", got_log.size() - 1, obs, recombine(obs));
            end
            if (acc) begin
                sb.push_back(enc(din, m_s));
                $display("in  data=%h", din);
                m_s = xs(m_s);
                m_cnt++;
                if (m_cnt == RP) m_state = 2;
            end
            if (sv) begin
                m_s     = (sin == 64'd0) ? 64'h1 : sin;
                m_cnt   = 0;
                m_state = 1;
                $display("seed %h", sin);
            end
        end
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_reset();
        syn_rst = 1'b1;
        cycle();
        syn_rst = 1'b0;
    endtask

    task automatic load_seed(input logic [63:0] seed);
        bus.seed_valid = 1'b1;
        bus.seed_in    = seed;
        cycle();
        bus.seed_valid = 1'b0;
    endtask

    initial begin
        int b, a0, idx;
        syn_rst        = 1'b1;
        bus.seed_valid = 1'b0;
        bus.seed_in    = '0;
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.out_ready  = 1'b0;
        #1;
        run(2);
        syn_rst = 1'b0;

        // Reset state
        check_val("rst.out_valid", 64'(bus.out_valid), 64'd0);
        check_val("rst.out_shares", 64'(bus.out_shares), 64'd0);
        check_val("rst.in_ready", 64'(bus.in_ready), 64'd0);
        check_val("rst.seed_req", 64'(bus.seed_req), 64'd1);

        // Seed 1, two encodings of A5
        b = got_log.size();
        load_seed(64'h1);
        bus.in_valid = 1'b1; bus.in_data = 8'hA5; bus.out_ready = 1'b1;
        run(2);
        bus.in_valid = 1'b0;
        run(2);
        check_val("t1.count", 64'(got_log.size() - b), 64'd2);
        if (got_log.size() >= b + 2) begin
            check_val("t1.o0.s0", 64'(get_share(got_log[b], 0)), 64'hA4);
            check_val("t1.o0.s1", 64'(get_share(got_log[b], 1)), 64'h01);
            check_val("t1.o0.rec", 64'(recombine(got_log[b])), 64'hA5);
            check_val("t1.o1.s0", 64'(get_share(got_log[b+1], 0)), 64'hE4);
            check_val("t1.o1.s1", 64'(get_share(got_log[b+1], 1)), 64'h41);
            check_val("t1.o1.rec", 64'(recombine(got_log[b+1])), 64'hA5);
        end

        // Zero seed behaves like seed 1
        do_reset();
        b = got_log.size();
        load_seed(64'h0);
        bus.in_valid = 1'b1; bus.in_data = 8'h00;
        run(1);
        bus.in_valid = 1'b0;
        run(2);
        check_val("t2.count", 64'(got_log.size() - b), 64'd1);
        if (got_log.size() >= b + 1) begin
            check_val("t2.s0", 64'(get_share(got_log[b], 0)), 64'h01);
            check_val("t2.s1", 64'(get_share(got_log[b], 1)), 64'h01);
        end

        // Back-pressure: one accept then a 5-cycle stall with in_valid held
        do_reset();
        load_seed(64'h0123456789ABCDEF);
        bus.in_valid = 1'b1; bus.in_data = 8'h3C; bus.out_ready = 1'b0;
        run(1);
        a0 = dut_acc;
        bus.in_data = 8'hC3;
        run(5);
        check_val("t3.stall_acc", 64'(dut_acc - a0), 64'd0);
        bus.out_ready = 1'b1;
        #1;
        check_val("t3.release_ready", 64'(bus.in_ready), 64'd1);
        run(1);
        bus.in_valid = 1'b0;
        run(2);
        check_val("t3.acc", 64'(dut_acc - a0), 64'd1);

        // Reseed request after RESEED_PERIOD encodings
        do_reset();
        load_seed(64'h9E3779B97F4A7C15);
        b  = got_log.size();
        a0 = dut_acc;
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.in_data = 8'($urandom_range(0, 255));
            cycle();
        end
        check_val("t4.acc", 64'(dut_acc - a0), 64'd4);
        check_val("t4.drained", 64'(got_log.size() - b), 64'd4);
        check_val("t4.seed_req", 64'(bus.seed_req), 64'd1);
        check_val("t4.in_ready", 64'(bus.in_ready), 64'd0);
        load_seed(64'h00000000000055AA);
        a0  = dut_acc;
        idx = got_log.size();
        for (int i = 0; i < 2; i++) begin
            bus.in_data = 8'($urandom_range(0, 255));
            cycle();
        end
        bus.in_valid = 1'b0;
        run(2);
        check_val("t4.acc2", 64'(dut_acc - a0), 64'd2);
        if (got_log.size() > idx)
            check_val("t4.newseed.s1", 64'(get_share(got_log[idx], 1)), 64'hAA);

        // Seed and data in the same cycle while running
        do_reset();
        load_seed(64'h1111111111111111);
        bus.in_valid = 1'b1; bus.in_data = 8'h5A; bus.out_ready = 1'b1;
        run(2);
        bus.seed_valid = 1'b1;
        bus.seed_in    = 64'hDEADBEEFCAFE1234;
        #1;
        check_val("t5.col_ready", 64'(bus.in_ready), 64'd0);
        a0 = dut_acc;
        cycle();
        bus.seed_valid = 1'b0;
        check_val("t5.col_acc", 64'(dut_acc - a0), 64'd0);
        idx = got_log.size();
        run(6);
        bus.in_valid = 1'b0;
        run(1);
        check_val("t5.acc", 64'(dut_acc - a0), 64'd4);
        check_val("t5.seed_req", 64'(bus.seed_req), 64'd1);
        if (got_log.size() > idx)
            check_val("t5.newseed.s1", 64'(get_share(got_log[idx], 1)), 64'h34);

        // Reset while an output is pending
        do_reset();
        load_seed(64'h0F0F0F0F0F0F0F0F);
        bus.in_valid = 1'b1; bus.in_data = 8'h77; bus.out_ready = 1'b0;
        run(1);
        check_val("t6.pending", 64'(bus.out_valid), 64'd1);
        do_reset();
        check_val("t6.out_valid", 64'(bus.out_valid), 64'd0);
        check_val("t6.out_shares", 64'(bus.out_shares), 64'd0);
        check_val("t6.seed_req", 64'(bus.seed_req), 64'd1);
        a0 = dut_acc;
        bus.out_ready = 1'b1;
        run(3);
        check_val("t6.ignored", 64'(dut_acc - a0), 64'd0);
        load_seed(64'h2);
        run(1);
        bus.in_valid = 1'b0;
        run(2);
        check_val("t6.resume", 64'(dut_acc - a0), 64'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Hard time bound in case the main sequence stalls
    initial begin
        #200000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
